// File: rtl/alu_md.sv
// Iterative multiply/divide unit: radix-2 shift-add multiply and restoring divide on
// operand magnitudes, followed by one sign fix-up cycle, with fixed latency for every op.
module alu_md #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       md_op,
  input  logic [WIDTH-1:0] bus_a,
  input  logic [WIDTH-1:0] bus_b,
  input  logic             kill,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] md_out,
  output logic             md_zero,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  // Handshakes: a request transfers on an edge with in_valid && in_ready && !kill;
  // a result transfers on an edge with out_valid && out_ready && !kill.
  state_t state, state_nx;

  logic [CNT_W-1:0] cnt;
  logic [2:0]       op_q;
  logic [WIDTH:0]   hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] m;
  logic             neg_q;
  logic [WIDTH-1:0] res;

  logic accept;
  logic last;
  assign accept = in_valid && (state == IDLE) && !kill;
  assign last   = (cnt == CNT_W'(WIDTH));

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = CALC;
      CALC:    if (last) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (kill) state_nx = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Operand preparation: magnitudes plus the sign the final result must carry.
  logic             a_sgn, b_sgn, a_neg, b_neg, b_zero, neg_in;
  logic [WIDTH-1:0] a_mag, b_mag;

  always_comb begin
    a_sgn  = (md_op == 3'd1) || (md_op == 3'd2) || (md_op == 3'd4) || (md_op == 3'd6);
    b_sgn  = (md_op == 3'd1) || (md_op == 3'd4) || (md_op == 3'd6);
    a_neg  = a_sgn && bus_a[WIDTH-1];
    b_neg  = b_sgn && bus_b[WIDTH-1];
    a_mag  = a_neg ? -bus_a : bus_a;
    b_mag  = b_neg ? -bus_b : bus_b;
    b_zero = (bus_b == '0);
    case (md_op)
      3'd1, 3'd2: neg_in = a_neg ^ b_neg;
      3'd4:       neg_in = (a_neg ^ b_neg) && !b_zero;  // x/0 stays all ones
      3'd6:       neg_in = a_neg;
      default:    neg_in = 1'b0;
    endcase
  end

  // One radix-2 step. Multiply: hi:lo is the product, lo shifts the multiplier out.
  // Divide: hi is the partial remainder, lo shifts dividend out and quotient in.
  logic [WIDTH:0]   sum, shifted, trial;
  logic [WIDTH:0]   hi_nx;
  logic [WIDTH-1:0] lo_nx;

  always_comb begin
    sum     = {1'b0, hi[WIDTH-1:0]} + {1'b0, (lo[0] ? m : '0)};
    shifted = {hi[WIDTH-1:0], lo[WIDTH-1]};
    trial   = shifted - {1'b0, m};
    if (!op_q[2]) begin
      hi_nx = {1'b0, sum[WIDTH:1]};
      lo_nx = {sum[0], lo[WIDTH-1:1]};
    end else if (!trial[WIDTH]) begin
      hi_nx = trial;
      lo_nx = {lo[WIDTH-2:0], 1'b1};
    end else begin
      hi_nx = shifted;
      lo_nx = {lo[WIDTH-2:0], 1'b0};
    end
  end

  logic [2*WIDTH-1:0] prod, prod_s;
  logic [WIDTH-1:0]   q_s, r_s, fix;

  always_comb begin
    prod   = {hi[WIDTH-1:0], lo};
    prod_s = neg_q ? -prod : prod;
    q_s    = neg_q ? -lo : lo;
    r_s    = neg_q ? -hi[WIDTH-1:0] : hi[WIDTH-1:0];
    case (op_q)
      3'd0:             fix = lo;
      3'd1, 3'd2, 3'd3: fix = prod_s[2*WIDTH-1:WIDTH];
      3'd4, 3'd5:       fix = q_s;
      default:          fix = r_s;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '0;
      op_q  <= '0;
      hi    <= '0;
      lo    <= '0;
      m     <= '0;
      neg_q <= 1'b0;
      res   <= '0;
    end else if (kill) begin
      cnt <= '0;
    end else if (accept) begin
      cnt   <= '0;
      op_q  <= md_op;
      neg_q <= neg_in;
      hi    <= '0;
      m     <= md_op[2] ? b_mag : a_mag;
      lo    <= md_op[2] ? a_mag : b_mag;
    end else if (state == CALC) begin
      if (last) begin
        res <= fix;
      end else begin
        hi  <= hi_nx;
        lo  <= lo_nx;
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);
  assign md_out    = out_valid ? res : '0;
  assign md_zero   = (md_out == '0);
  assign dbg_state = state;

endmodule

// File: tb/tb_alu_md.sv
// Randomized and directed bench for alu_md against a plain 64-bit arithmetic model.
module tb_alu_md;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, in_valid, kill, out_ready;
  logic         in_ready, out_valid, md_zero, busy;
  logic [2:0]   md_op;
  logic [W-1:0] bus_a, bus_b, md_out;
  logic [1:0]   dbg_state;

  int           tests = 0;
  int           fails = 0;
  logic [W-1:0] exp_q[$];
  bit           chk_en = 1'b0;

  alu_md #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .md_op(md_op), .bus_a(bus_a), .bus_b(bus_b), .kill(kill),
    .out_valid(out_valid), .out_ready(out_ready), .md_out(md_out),
    .md_zero(md_zero), .busy(busy), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic logic [W-1:0] ref_md(input logic [2:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    longint     sa, sb, ub;
    logic [63:0] p;
    int         ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'b0, b});
    ia = $signed(a);
    ib = $signed(b);
    case (op)
      3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return '1;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return 32'(ia / ib);
      end
      3'd5: return (b == 0) ? '1 : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return '0;
        return 32'(ia % ib);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // scoreboard: every cycle, outputs compared against the expected queue
  always @(negedge clk) begin
    if (chk_en) begin
      if (out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL spurious_valid: got out_valid=1 expected 0");
        end else begin
          check("md_out", md_out, exp_q[0]);
          check("md_zero", 32'(md_zero), 32'(exp_q[0] == 0));
          if (out_ready && !kill && !reset) void'(exp_q.pop_front());
        end
      end else begin
        check("idle_md_out", md_out, '0);
        check("idle_md_zero", 32'(md_zero), 32'd1);
      end
      check("ready_vs_busy", 32'(in_ready), 32'(!busy));
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    in_valid = 1'b1;
    md_op    = op;
    bus_a    = a;
    bus_b    = b;
    check("in_ready_pre", 32'(in_ready), 32'd1);
    exp_q.push_back(ref_md(op, a, b));
    tick();
    in_valid = 1'b0;
    md_op    = 3'($urandom);
    bus_a    = $urandom;
    bus_b    = $urandom;
    check("busy_after_accept", 32'(busy), 32'd1);
  endtask

  task automatic wait_result(input int hold);
    int lat = 0;
    out_ready = (hold == 0);
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (out_valid !== 1'b1 && lat < 100);
    check("latency", 32'(lat), 32'(W + 1));
    if (out_valid !== 1'b1) begin
      exp_q.delete();
      out_ready = 1'b1;
      tick();
      return;
    end
    if (hold > 0) begin
      repeat (hold) begin
        tick();
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_valid", 32'(out_valid), 32'd1);
      end
      out_ready = 1'b1;
    end
    tick();
    check("post_valid", 32'(out_valid), 32'd0);
    check("post_in_ready", 32'(in_ready), 32'd1);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  logic [2:0]   d_op[9] = '{3'd0, 3'd3, 3'd4, 3'd6, 3'd5, 3'd4, 3'd7, 3'd4, 3'd6};
  logic [W-1:0] d_a[9]  = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFFF,
                            32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
  logic [W-1:0] d_b[9]  = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd2, 32'd2, 32'h10,
                            32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};

  initial begin
    reset = 1'b1; in_valid = 1'b0; kill = 1'b0; out_ready = 1'b1;
    md_op = '0; bus_a = '0; bus_b = '0;
    repeat (3) tick();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_md_out", md_out, '0);
    check("rst_md_zero", 32'(md_zero), 32'd1);
    reset  = 1'b0;
    chk_en = 1'b1;

    // hand-computed literals pin the model
    check("pin_mul", ref_md(3'd0, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
    check("pin_mulhu", ref_md(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFE);
    check("pin_div", ref_md(3'd4, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
    check("pin_rem", ref_md(3'd6, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
    check("pin_divu", ref_md(3'd5, 32'hFFFF_FFFF, 32'h10), 32'h0FFF_FFFF);
    check("pin_div0", ref_md(3'd4, 32'd5, 32'd0), 32'hFFFF_FFFF);
    check("pin_remu0", ref_md(3'd7, 32'd5, 32'd0), 32'd5);
    check("pin_ovf_div", ref_md(3'd4, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);
    check("pin_ovf_rem", ref_md(3'd6, 32'h8000_0000, 32'hFFFF_FFFF), 32'd0);
    check("pin_mulhsu", ref_md(3'd2, 32'hFFFF_FFFF, 32'd2), 32'hFFFF_FFFF);
    check("pin_mulh", ref_md(3'd1, 32'hFFFF_FFFF, 32'd2), 32'hFFFF_FFFF);

    for (int i = 0; i < 9; i++) begin
      accept(d_op[i], d_a[i], d_b[i]);
      wait_result(0);
    end

    // backpressure for 10 cycles
    accept(3'd2, 32'h1234_5678, 32'h9ABC_DEF0);
    wait_result(10);

    // kill mid-calculation, then a fresh op
    accept(3'd0, $urandom, $urandom);
    repeat (11) tick();
    kill = 1'b1;
    tick();
    kill = 1'b0;
    exp_q.delete();
    check("kill_busy", 32'(busy), 32'd0);
    check("kill_valid", 32'(out_valid), 32'd0);
    repeat (40) tick();
    accept(3'd2, 32'hFFFF_FFFF, 32'd2);
    wait_result(0);

    // kill with in_valid in IDLE must not accept
    in_valid = 1'b1;
    kill     = 1'b1;
    tick();
    in_valid = 1'b0;
    kill     = 1'b0;
    check("kill_idle_busy", 32'(busy), 32'd0);

    // reset mid-calculation
    accept(3'd4, 32'd1000, 32'd7);
    repeat (5) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_in_ready", 32'(in_ready), 32'd1);
    check("rst_mid_valid", 32'(out_valid), 32'd0);
    repeat (40) tick();
    accept(3'd5, 32'd1000, 32'd7);
    wait_result(0);

    // randomized traffic
    for (int i = 0; i < 150; i++) begin
      accept(3'($urandom_range(0, 7)), pick(), pick());
      wait_result($urandom_range(0, 3));
    end

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
